// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the memory.
//
// Handshake: the controller raises mem_req and holds mem_we/mem_addr/mem_wdata
// stable until the memory pulses mem_ack for exactly one cycle. mem_rdata is only
// meaningful in that ack cycle. A request ends either on ack or when the
// controller withdraws mem_req after its timeout. Any ack seen while mem_req is
// low is ignored.
//
// Signals:
//   mem_req    controller -> memory  request pending
//   mem_we     controller -> memory  1 = write, 0 = read
//   mem_addr   controller -> memory  word-aligned byte address
//   mem_wdata  controller -> memory  store data
//   mem_ack    memory -> controller  request completes this cycle
//   mem_rdata  memory -> controller  load data, valid with mem_ack
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Sits between EX/MEM and MEM/WB. Loads and stores drive a variable-latency
// memory over the mem_access_ctrl_if bus and stall the upstream pipeline until
// the access completes. Non-memory instructions pass through in zero cycles.
// Misaligned accesses and memory timeouts set a sticky error flag.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i               EX/MEM holds a real instruction
//   MemRead_i/MemWrite_i  load / store (both set = store)
//   RegWrite_i            instruction writes the register file
//   MemtoReg_i            write-back selects memory data
//   Addr_i                ALU result / byte address
//   WriteData_i           store data
//   RegWaddr_i            destination register
//   stall_o               freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   RegWrite_o..RegWaddr_o  write-back bundle to MEM/WB
//   err_o                 sticky error, cleared only by reset
//   dbg_state_o           FSM state (0 IDLE, 1 BUSY, 2 DONE)
//   mem                   memory bus, master side
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RegWaddr_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUdata_o,
  output logic [4:0]  RegWaddr_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o,
  mem_access_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_kill;
  logic              r_err;

  logic w_memop;
  logic w_misal;

  assign w_memop = valid_i & (MemRead_i | MemWrite_i);
  assign w_misal = |Addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_kill  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            if (w_misal) begin
              // Misaligned access is dropped; the instruction retires as a bubble.
              r_err <= 1'b1;
            end else begin
              r_req   <= 1'b1;
              r_we    <= MemWrite_i;
              r_addr  <= {Addr_i[31:2], 2'b00};
              r_wdata <= WriteData_i;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mem.mem_ack) begin
            r_rdata <= r_we ? 32'd0 : mem.mem_rdata;
            r_kill  <= 1'b0;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abort: suppress the register write of this instruction.
            r_req   <= 1'b0;
            r_rdata <= '0;
            r_kill  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_o    = 1'b0;
    RegWrite_o = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE: begin
          stall_o    = w_memop & ~w_misal;
          RegWrite_o = RegWrite_i & valid_i & ~w_memop;
        end
        S_BUSY: begin
          stall_o    = 1'b1;
          RegWrite_o = 1'b0;
        end
        S_DONE: begin
          stall_o    = 1'b0;
          RegWrite_o = RegWrite_i & ~r_kill;
        end
        default: begin
          stall_o    = 1'b0;
          RegWrite_o = 1'b0;
        end
      endcase
    end
  end

  assign MemtoReg_o    = MemtoReg_i;
  assign ReadData_o    = r_rdata;
  assign ALUdata_o     = Addr_i;
  assign RegWaddr_o    = RegWaddr_i;
  assign err_o         = r_err;
  assign dbg_state_o   = r_state;

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic [4:0]  RegWaddr_i;
  logic        stall_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic [31:0] ReadData_o;
  logic [31:0] ALUdata_o;
  logic [4:0]  RegWaddr_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  mem_access_ctrl_if mem_if ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .RegWaddr_i  (RegWaddr_i),
    .stall_o     (stall_o),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .ReadData_o  (ReadData_o),
    .ALUdata_o   (ALUdata_o),
    .RegWaddr_o  (RegWaddr_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state_o),
    .mem         (mem_if.master)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  // retire bundle: {RegWrite, MemtoReg, ReadData, ALUdata, RegWaddr}
  logic [70:0] exp_q[$];
  // memory request: {we, addr, wdata}
  logic [64:0] req_q[$];

  task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- monitors ----------------
  // Retire monitor: an instruction leaves MEM when valid and not stalled.
  always @(negedge clk_i) begin
    logic [70:0] e;
    if (!rst_i && valid_i && !stall_o) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL retire_unexpected: got %0h expected none",
                 {RegWrite_o, MemtoReg_o, ReadData_o, ALUdata_o, RegWaddr_o});
      end else begin
        e = exp_q.pop_front();
        chk("retire", {RegWrite_o, MemtoReg_o, ReadData_o, ALUdata_o, RegWaddr_o}, e);
      end
    end
  end

  // Memory-bus monitor: new request is matched against the queue, and every
  // further cycle of the same request must still present the expected fields.
  logic        prev_req = 1'b0;
  logic [64:0] hold_exp = '0;
  always @(negedge clk_i) begin
    logic [64:0] cur;
    cur = {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata};
    if (mem_if.mem_req && !prev_req) begin
      if (req_q.size() == 0) begin
        total_cnt++;
        $display("FAIL mem_req_unexpected: got %0h expected none", cur);
      end else begin
        hold_exp = req_q.pop_front();
        chk("mem_req", 71'(cur), 71'(hold_exp));
      end
    end else if (mem_if.mem_req && prev_req) begin
      chk("mem_hold", 71'(cur), 71'(hold_exp));
    end
    prev_req = mem_if.mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    valid_i     = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    RegWrite_i  = 1'b0;
    MemtoReg_i  = 1'b0;
    Addr_i      = '0;
    WriteData_i = '0;
    RegWaddr_i  = '0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'hBAD0BAD0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_state", 71'(dbg_state_o), 71'(ST_IDLE));
    chk("rst_req",   71'(mem_if.mem_req), 71'(0));
    chk("rst_we",    71'(mem_if.mem_we), 71'(0));
    chk("rst_addr",  71'(mem_if.mem_addr), 71'(0));
    chk("rst_wdata", 71'(mem_if.mem_wdata), 71'(0));
    chk("rst_rdata", 71'(ReadData_o), 71'(0));
    chk("rst_err",   71'(err_o), 71'(0));
    chk("rst_stall", 71'(stall_o), 71'(0));
  endtask

  // Issue one instruction (called at posedge+1), answer the memory after
  // ack_k request cycles (0 = never), and run until it retires.
  task automatic run_op(input string nm,
                        input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wa,
                        input int ack_k, input logic [31:0] rdat,
                        input int exp_stalls, input int exp_nreq,
                        input logic exp_rw, input logic [31:0] exp_rd);
    int  stalls;
    int  nreq;
    bit  done;
    exp_q.push_back({exp_rw, m2r, exp_rd, addr, wa});
    if (exp_nreq > 0) req_q.push_back({wr, addr, wd});
    valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw;
    MemtoReg_i = m2r; Addr_i = addr; WriteData_i = wd; RegWaddr_i = wa;
    stalls = 0; nreq = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 32'hBAD0BAD0;
      if (mem_if.mem_req) begin
        nreq++;
        if (nreq == ack_k) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = rdat;
        end
      end
      #1;
      if (stall_o) stalls++;
      else done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s_timeout: got no retire within 40 cycles expected retire", nm);
    end
    chk({nm, "_stalls"}, 71'(stalls), 71'(exp_stalls));
    chk({nm, "_nreq"},   71'(nreq),   71'(exp_nreq));
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    idle_inputs();
    do_reset();
    check_reset_state();

    // bubble with RegWrite_i set must not write
    RegWrite_i = 1'b1; #1;
    chk("bubble_rw", 71'(RegWrite_o), 71'(0));
    idle_inputs();
    @(posedge clk_i); #1;

    // 1) non-memory op passes through in zero cycles
    run_op("alu", 0, 0, 1, 0, 32'h1234, 32'h0, 5'd7, 0, 32'h0, 0, 0, 1'b1, 32'h0);
    // 2) load, ack in first BUSY cycle
    run_op("load1", 1, 0, 1, 1, 32'h40, 32'h0, 5'd3, 1, 32'hDEADBEEF, 2, 1, 1'b1, 32'hDEADBEEF);
    // 3) store, ack after 3 BUSY cycles
    run_op("store3", 0, 1, 0, 0, 32'h80, 32'hA5A5A5A5, 5'd0, 3, 32'h0, 4, 3, 1'b0, 32'h0);
    chk("store_err", 71'(err_o), 71'(0));
    // 4) misaligned load: no access, retires as bubble, error sticks
    run_op("misal", 1, 0, 1, 1, 32'h42, 32'h0, 5'd5, 0, 32'h0, 0, 0, 1'b0, 32'h0);
    chk("misal_err", 71'(err_o), 71'(1));
    repeat (3) @(posedge clk_i);
    #1;
    chk("misal_err_sticky", 71'(err_o), 71'(1));

    do_reset();
    check_reset_state();

    // load with ack on second BUSY cycle
    run_op("load2", 1, 0, 1, 1, 32'h100, 32'h0, 5'd9, 2, 32'h12345678, 3, 2, 1'b1, 32'h12345678);
    // read+write together acts as a store; stale read data cleared
    run_op("rdwr", 1, 1, 0, 0, 32'hC, 32'h55AA55AA, 5'd1, 1, 32'hFFFFFFFF, 2, 1, 1'b0, 32'h0);
    // 5) timeout: never acked
    run_op("tmo", 1, 0, 1, 1, 32'h200, 32'h0, 5'd10, 0, 32'h0, 5, 4, 1'b0, 32'h0);
    chk("tmo_err", 71'(err_o), 71'(1));
    chk("tmo_state", 71'(dbg_state_o), 71'(ST_IDLE));

    // leave non-zero read data before the reset test
    run_op("load3", 1, 0, 1, 1, 32'h300, 32'h0, 5'd4, 1, 32'h0BADCAFE, 2, 1, 1'b1, 32'h0BADCAFE);

    // 6) reset during second BUSY cycle, then a late ack
    req_q.push_back({1'b0, 32'h400, 32'h0});
    valid_i = 1'b1; MemRead_i = 1'b1; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
    Addr_i = 32'h400; RegWaddr_i = 5'd6;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("r6_busy_stall", 71'(stall_o), 71'(1));
    rst_i = 1'b1; #1;
    chk("r6_rst_stall", 71'(stall_o), 71'(0));
    chk("r6_rst_rw", 71'(RegWrite_o), 71'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle_inputs();
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hCAFEF00D;
    check_reset_state();
    @(posedge clk_i); #1;
    mem_if.mem_ack = 1'b0;
    chk("r6_late_state", 71'(dbg_state_o), 71'(ST_IDLE));
    chk("r6_late_req",   71'(mem_if.mem_req), 71'(0));
    chk("r6_late_rdata", 71'(ReadData_o), 71'(0));

    repeat (2) @(posedge clk_i);
    #1;
    chk("retire_q_empty", 71'(exp_q.size()), 71'(0));
    chk("req_q_empty",    71'(req_q.size()), 71'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
